gray_conv_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `binary_to_gray` converter among `N` requesters. Each requester offers a binary word on a valid/ready handshake. The arbiter grants one requester per cycle, converts the word, and presents the Gray result in a single registered output slot tagged with the requester ID. It sits between multiple counter/pointer sources (e.g. FIFO pointer generators) and downstream consumers that need Gray-coded values.

---
 rtl/gray_arb_pkg.sv | 19 +
 rtl/binary_to_gray.sv | 13 +
 rtl/gray_conv_arbiter.sv | 129 ++++++++++++
 tb/tb_gray_conv_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gray_arb_pkg.sv
// Purpose : shared defaults and helpers for the Gray-conversion arbiter.
// Contents: default requester count / data width, ID width calculation,
//           and a reference binary-to-Gray function for software models.
package gray_arb_pkg;

  localparam int N_DEF     = 4;
  localparam int WIDTH_DEF = 4;

  // ID width for N requesters; never narrower than one bit.
  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Reference conversion, wide enough for any supported WIDTH.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Purpose : combinational binary-to-Gray converter.
// Latency : 0 cycles (pure combinational); no backpressure, no state.
// Ports   : bin (binary in), gray (Gray out), both WIDTH bits.
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Purpose : round-robin arbiter sharing one binary_to_gray converter among N requesters.
// Latency : 1 cycle from accept edge to out_valid/out_gray; 1 result per cycle sustained.
// Backpr. : while out_valid && !out_ready the slot holds and req_ready is all zeros.
// Ports   : clk/rst_n; req_valid/req_bin/req_ready per requester (word i at
//           [i*WIDTH +: WIDTH]); out_valid/out_ready handshake with registered
//           out_gray, out_bin and out_id.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = idw(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_bin,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_gray,
  output logic [WIDTH-1:0]   out_bin,
  output logic [IDW-1:0]     out_id
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_gray_q,  out_gray_d;
  logic [WIDTH-1:0] out_bin_q,   out_bin_d;
  logic [IDW-1:0]   out_id_q,    out_id_d;
  logic [IDW-1:0]   ptr_q,       ptr_d;

  logic             can_accept;
  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [IDW:0]     cand_sum;
  logic [IDW-1:0]   cand_idx;
  logic             xfer;
  logic [WIDTH-1:0] win_bin;
  logic [WIDTH-1:0] win_gray;
  logic [N-1:0]     grant_vec;
  logic [WIDTH-1:0] words [N];

  assign can_accept = !out_valid_q || out_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      words[i] = req_bin[i*WIDTH +: WIDTH];
    end
  end

  // Walk the search order from the far end back toward ptr so the last
  // overwrite is the requester closest to ptr, i.e. the round-robin winner.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(N)) begin
        cand_sum = cand_sum - (IDW+1)'(N);
      end
      cand_idx = cand_sum[IDW-1:0];
      if (req_valid[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign xfer    = win_vld && can_accept && rst_n;
  assign win_bin = words[win_idx];

  binary_to_gray #(
    .WIDTH (WIDTH)
  ) u_b2g (
    .bin  (win_bin),
    .gray (win_gray)
  );

  always_comb begin
    grant_vec = '0;
    if (xfer) begin
      grant_vec[win_idx] = 1'b1;
    end
  end

  assign req_ready = grant_vec;

  always_comb begin
    out_valid_d = out_valid_q;
    out_gray_d  = out_gray_q;
    out_bin_d   = out_bin_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      // Covers drain-and-reload in the same cycle: valid simply stays high.
      out_valid_d = 1'b1;
      out_gray_d  = win_gray;
      out_bin_d   = win_bin;
      out_id_d    = win_idx;
      ptr_d       = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_gray_q  <= '0;
      out_bin_q   <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_gray_q  <= out_gray_d;
      out_bin_q   <= out_bin_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_gray  = out_gray_q;
  assign out_bin   = out_bin_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Purpose : directed self-checking bench for gray_conv_arbiter (N=4, WIDTH=4).
// Latency : inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpr. : out_ready is driven explicitly by each scenario.
module tb_gray_conv_arbiter;
  import gray_arb_pkg::*;

  localparam int N     = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_bin;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_gray;
  logic [WIDTH-1:0]   out_bin;
  logic [IDW-1:0]     out_id;

  int checks = 0;
  int errors = 0;

  gray_conv_arbiter #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    req_bin[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] g,
                         input logic [3:0] b, input logic [1:0] id);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_gray"},  32'(out_gray),  32'(g));
    chk({tag, "_bin"},   32'(out_bin),   32'(b));
    chk({tag, "_id"},    32'(out_id),    32'(id));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_ids  [5];
    logic [3:0] exp_gray [5];
    logic [3:0] exp_bin  [5];
    logic [31:0] g;

    rst_n     = 1'b0;
    req_valid = '0;
    req_bin   = '0;
    out_ready = 1'b1;

    // Reset state, with requests pending to show req_ready is held low.
    req_valid = 4'hF;
    #2;
    chk_out("rst", 1'b0, 4'h0, 4'h0, 2'd0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single requester.
    set_word(1, 4'b0011);
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    chk_out("single", 1'b1, 4'b0010, 4'b0011, 2'd1);
    step();
    chk("single_drain", 32'(out_valid), 32'd0);

    // All four continuously valid from ptr=0.
    do_reset();
    set_word(0, 4'b0000);
    set_word(1, 4'b0001);
    set_word(2, 4'b0100);
    set_word(3, 4'b1111);
    req_valid = 4'hF;
    out_ready = 1'b1;
    exp_ids  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    exp_gray = '{4'b0000, 4'b0001, 4'b0110, 4'b1000, 4'b0000};
    exp_bin  = '{4'b0000, 4'b0001, 4'b0100, 4'b1111, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out($sformatf("rr%0d", k), 1'b1, exp_gray[k], exp_bin[k], exp_ids[k][1:0]);
    end
    // One more grant so the held slot is distinguishable from reset values.
    step();
    chk_out("rr5", 1'b1, 4'b0001, 4'b0001, 2'd1);

    // Backpressure: slot holds requester 1's result, ptr=2.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
      step();
      chk_out($sformatf("bp%0d", k), 1'b1, 4'b0001, 4'b0001, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    step();
    chk_out("bp_release", 1'b1, 4'b0110, 4'b0100, 2'd2);

    // Pointer wrap/skip: ptr=3, only requesters 1 and 3 valid.
    req_valid = 4'b1010;
    #1;
    chk("wrap_ready3", 32'(req_ready), 32'b1000);
    step();
    chk_out("wrap3", 1'b1, 4'b1000, 4'b1111, 2'd3);
    chk("wrap_ready1", 32'(req_ready), 32'b0010);
    step();
    chk_out("wrap1", 1'b1, 4'b0001, 4'b0001, 2'd1);
    req_valid = '0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    step();
    chk("idle_drain", 32'(out_valid), 32'd0);

    // Reset mid-operation under backpressure (ptr=2 -> grant 2).
    req_valid = 4'hF;
    step();
    chk_out("pre_rst", 1'b1, 4'b0110, 4'b0100, 2'd2);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 4'h0, 4'h0, 2'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    step();
    chk_out("post_rst", 1'b1, 4'b0000, 4'b0000, 2'd0);

    // Exhaustive conversion through requester 2, one result per cycle.
    req_valid = 4'b0100;
    for (int v = 0; v < 16; v++) begin
      set_word(2, 4'(v));
      #1;
      chk($sformatf("sweep%0d_ready", v), 32'(req_ready), 32'b0100);
      step();
      g = bin2gray(32'(v));
      chk_out($sformatf("sweep%0d", v), 1'b1, g[3:0], 4'(v), 2'd2);
    end
    req_valid = '0;
    step();
    chk("final_drain", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
